// File: rtl/fetch_stage.sv
// Fetch stage: program counter, word-addressed instruction memory with a load port,
// and the IF/ID register. Define FETCH_PERF_CNT_EN to add fetch/stall counters.
module fetch_stage #(
  parameter int PC_SIZE = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               StallF,
  input  logic               StallD,
  input  logic               PCSrcD,
  input  logic [PC_SIZE-1:0] PCBranchD,
  input  logic               ImemWE,
  input  logic [PC_SIZE-1:0] ImemWA,
  input  logic [31:0]        ImemWD,
  output logic [PC_SIZE-1:0] PCF,
  output logic [31:0]        InstrD,
  output logic [PC_SIZE-1:0] PCPlus1D
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        FetchCountF,
  output logic [31:0]        StallCountF
`endif
);

  localparam int DEPTH = 1 << PC_SIZE;

  logic [31:0]        imem [DEPTH];
  logic [PC_SIZE-1:0] pc_q, pc_d;
  logic [PC_SIZE-1:0] pc_plus1_f;
  logic [31:0]        instr_f;
  logic [31:0]        instr_d_q, instr_d_d;
  logic [PC_SIZE-1:0] pc_plus1_d_q, pc_plus1_d_d;

  // Asynchronous read: a same-edge write is not seen by IF/ID until the next cycle.
  assign instr_f    = imem[pc_q];
  assign pc_plus1_f = pc_q + PC_SIZE'(1);

  always_ff @(posedge clk) begin
    if (ImemWE) begin
      imem[ImemWA] <= ImemWD;
    end
  end

  always_comb begin
    pc_d         = pc_q;
    instr_d_d    = instr_d_q;
    pc_plus1_d_d = pc_plus1_d_q;
    if (!StallF) begin
      pc_d = PCSrcD ? PCBranchD : pc_plus1_f;
    end
    // A taken branch squashes the wrong-path instruction into a nop.
    if (!StallD) begin
      if (PCSrcD) begin
        instr_d_d    = 32'h0;
        pc_plus1_d_d = '0;
      end else begin
        instr_d_d    = instr_f;
        pc_plus1_d_d = pc_plus1_f;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= '0;
      instr_d_q    <= 32'h0;
      pc_plus1_d_q <= '0;
    end else begin
      pc_q         <= pc_d;
      instr_d_q    <= instr_d_d;
      pc_plus1_d_q <= pc_plus1_d_d;
    end
  end

  assign PCF      = pc_q;
  assign InstrD   = instr_d_q;
  assign PCPlus1D = pc_plus1_d_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (!StallD && !PCSrcD && fetch_cnt_q != 32'hFFFF_FFFF) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (StallF && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign FetchCountF = fetch_cnt_q;
  assign StallCountF = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed test-plan sequences followed by
// randomized stall/branch/load traffic, all checked against a behavioural model.
module tb_fetch_stage;

  localparam int PC_SIZE = 8;
  localparam int DEPTH   = 256;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               StallF, StallD, PCSrcD, ImemWE;
  logic [PC_SIZE-1:0] PCBranchD, ImemWA;
  logic [31:0]        ImemWD;
  logic [PC_SIZE-1:0] PCF, PCPlus1D;
  logic [31:0]        InstrD;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]        FetchCountF, StallCountF;
`endif

  fetch_stage #(.PC_SIZE(PC_SIZE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .StallF     (StallF),
    .StallD     (StallD),
    .PCSrcD     (PCSrcD),
    .PCBranchD  (PCBranchD),
    .ImemWE     (ImemWE),
    .ImemWA     (ImemWA),
    .ImemWD     (ImemWD),
    .PCF        (PCF),
    .InstrD     (InstrD),
    .PCPlus1D   (PCPlus1D)
`ifdef FETCH_PERF_CNT_EN
    ,
    .FetchCountF(FetchCountF),
    .StallCountF(StallCountF)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] mem_m [DEPTH];
  int          pc_m, p1d_m;
  logic [31:0] instrd_m;
  longint      fcnt_m, scnt_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    pc_m = 0; instrd_m = 32'h0; p1d_m = 0; fcnt_m = 0; scnt_m = 0;
  endtask

  // One rising edge worth of behaviour, from the currently driven inputs.
  task automatic model_edge();
    logic [31:0] instr_f;
    int          p1_f;
    instr_f = mem_m[pc_m];
    p1_f    = (pc_m + 1) % DEPTH;
    if (rst_n) begin
      if (!StallD) begin
        if (PCSrcD) begin instrd_m = 32'h0; p1d_m = 0; end
        else        begin instrd_m = instr_f; p1d_m = p1_f; end
      end
      if (!StallF) pc_m = PCSrcD ? int'(PCBranchD) : p1_f;
      if (!StallD && !PCSrcD && fcnt_m < 64'hFFFF_FFFF) fcnt_m++;
      if (StallF && scnt_m < 64'hFFFF_FFFF) scnt_m++;
    end else begin
      model_reset();
    end
    if (ImemWE) mem_m[ImemWA] = ImemWD;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".PCF"},      32'(PCF),      32'(pc_m));
    chk({tag, ".InstrD"},   InstrD,        instrd_m);
    chk({tag, ".PCPlus1D"}, 32'(PCPlus1D), 32'(p1d_m));
`ifdef FETCH_PERF_CNT_EN
    chk({tag, ".FetchCnt"}, FetchCountF,   32'(fcnt_m));
    chk({tag, ".StallCnt"}, StallCountF,   32'(scnt_m));
`endif
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    StallF = 0; StallD = 0; PCSrcD = 0; PCBranchD = '0;
    ImemWE = 0; ImemWA = '0; ImemWD = '0;
  endtask

  task automatic branch_to(input logic [PC_SIZE-1:0] tgt, input string tag);
    PCSrcD = 1; PCBranchD = tgt;
    step(tag);
    PCSrcD = 0;
  endtask

  initial begin
    int sf;
    idle_inputs();
    rst_n = 0;
    model_reset();
    #2;
    check_all("reset");

    // Program load while held in reset; memory is not cleared by reset.
    for (int a = 0; a < DEPTH; a++) begin
      ImemWE = 1; ImemWA = PC_SIZE'(a);
      ImemWD = (a < 4) ? 32'(17 * (a + 1)) * 32'h2 / 32'h2 : $urandom;
      if (a < 4) ImemWD = {28'h0, 4'(a + 1)} * 32'h11;
      step("load");
    end
    idle_inputs();
    #3 rst_n = 1;
    #1 check_all("post_release");

    // Sequential fetch
    step("seq1"); chk("seq1.lit", InstrD, 32'h11);
    step("seq2"); chk("seq2.lit", InstrD, 32'h22);

    // Stall at PCF=2
    StallF = 1; StallD = 1;
    step("stall1"); step("stall2");
    chk("stall.pc_lit", 32'(PCF), 32'd2);
    StallF = 0; StallD = 0;
    step("unstall"); chk("unstall.lit", InstrD, 32'h33);

    // Taken branch and squash
    branch_to(8'hF0, "br_f0");
    chk("br_f0.squash", InstrD, 32'h0);
    step("br_f0_tgt");

    // Wrap at top of memory
    branch_to(8'hFF, "br_ff");
    step("wrap_ff"); chk("wrap_ff.p1_lit", 32'(PCPlus1D), 32'h0);
    step("wrap_0");

    // Branch while fully stalled: no state change
    StallF = 1; StallD = 1;
    branch_to(8'h55, "br_stalled");
    StallF = 0; StallD = 0;
    step("after_br_stalled");

    // Write to current PCF: IF/ID sees the old word, rewind sees the new one
    sf = int'(PCF);
    ImemWE = 1; ImemWA = PCF; ImemWD = 32'hDEAD_BEEF;
    step("wr_cur");
    ImemWE = 0;
    branch_to(PC_SIZE'(sf), "rewind");
    step("rewind_tgt"); chk("rewind.lit", InstrD, 32'hDEAD_BEEF);

    // Asynchronous reset mid-cycle, then counter scenario
    #2 rst_n = 0;
    model_reset();
    #1 check_all("async_rst");
    #3 rst_n = 1;
    for (int i = 0; i < 10; i++) step("cnt_fetch");
    StallF = 1; StallD = 1;
    for (int i = 0; i < 3; i++) step("cnt_stall");
    StallF = 0; StallD = 0;
    branch_to(8'h10, "cnt_br");
`ifdef FETCH_PERF_CNT_EN
    chk("cnt.fetch_lit", FetchCountF, 32'd10);
    chk("cnt.stall_lit", StallCountF, 32'd3);
`endif

    // Randomized traffic; StallD only ever asserted together with StallF
    for (int i = 0; i < 400; i++) begin
      StallF    = ($urandom_range(0, 3) == 0);
      StallD    = StallF & $urandom_range(0, 1);
      PCSrcD    = ($urandom_range(0, 4) == 0);
      PCBranchD = PC_SIZE'($urandom);
      ImemWE    = ($urandom_range(0, 9) == 0);
      ImemWA    = ($urandom_range(0, 1) == 0) ? PCF : PC_SIZE'($urandom);
      ImemWD    = $urandom;
      step("rand");
    end
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core, directly upstream of the decode stage. Holds the program counter, an on-chip word-addressed instruction memory with a load port, and the IF/ID pipeline register that drives `InstrD` and `PCPlus1D` into decode. It honours the hazard unit's `StallF`/`StallD`, and consumes decode's branch resolution (`PCSrcD`, `PCBranchD`) to redirect fetch and squash the wrong-path instruction.

## Interface
- `PC_SIZE`, default 8: PC width in bits. Instruction memory depth is 2^PC_SIZE 32-bit words. The PC counts words, not bytes.
- `clk`  in  1: single clock. All state updates on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `StallF`  in  1: hold the PC.
- `StallD`  in  1: hold the IF/ID register.
- `PCSrcD`  in  1: branch taken, resolved in decode.
- `PCBranchD`  in  PC_SIZE: branch target from decode.
- `ImemWE`  in  1: instruction-memory write enable (program load).
- `ImemWA`  in  PC_SIZE: write word address.
- `ImemWD`  in  32: write data.
- `PCF`  out  PC_SIZE: current fetch PC.
- `InstrD`  out  32: instruction handed to decode.
- `PCPlus1D`  out  PC_SIZE: PC+1 of `InstrD`.
- `FetchCountF`  out  32: present only with `FETCH_PERF_CNT_EN`.
- `StallCountF`  out  32: present only with `FETCH_PERF_CNT_EN`.

## Operation
- **Combinational fetch path**
  - `InstrF = imem[PCF]`, read asynchronously.
  - `PCPlus1F = PCF + 1`, truncated to PC_SIZE bits; wraps from 2^PC_SIZE−1 to 0.
- **PC register**
  - `rst_n` = 0: `PCF` = 0.
  - Else, `StallF` = 1: hold.
  - Else, `PCSrcD` = 1: load `PCBranchD`.
  - Else: load `PCPlus1F`.
- **IF/ID register**
  - `rst_n` = 0: `InstrD` = 0 (nop) and `PCPlus1D` = 0.
  - Else, `StallD` = 1: hold both. `PCSrcD` is ignored.
  - Else, `PCSrcD` = 1: clear both to 0. This squashes the wrong-path instruction.
  - Else: capture `InstrF` and `PCPlus1F`.
- **Instruction memory**
  - `ImemWE` = 1 writes `ImemWD` to `imem[ImemWA]` at the rising edge.
  - Reset does not clear the memory. Contents after power-up are X unless loaded.
- **Hazard-unit contract:** `StallD` implies `StallF`. The block does not check this. If `StallF` = 0 and `StallD` = 1, the PC advances and one instruction is lost; that case is undefined at system level.

## Timing
- PC to `InstrD` latency: 1 cycle. The instruction at `PCF` in cycle N appears on `InstrD` in cycle N+1.
- Taken branch:
  - `PCSrcD` high in cycle N (with `StallF`/`StallD` low) gives `PCF` = `PCBranchD` and `InstrD` = 0 in cycle N+1.
  - The target instruction reaches `InstrD` in cycle N+2.
- `PCSrcD` together with `StallF` = `StallD` = 1: no state change. Decode re-presents the branch next cycle.
- Write to `ImemWA` = `PCF` at the edge ending cycle N:
  - IF/ID captures the pre-write word at that edge.
  - The new word is visible on `InstrF` from cycle N+1.
- Asynchronous reset mid-operation:
  - `PCF`, `InstrD`, `PCPlus1D` and the counters go to 0 immediately, independent of `clk`.
  - The first fetch from address 0 is captured at the first rising edge after `rst_n` deasserts.

## Configuration
- `FETCH_PERF_CNT_EN` defined adds `FetchCountF` and `StallCountF`. Both reset to 0 and saturate at 32'hFFFF_FFFF.
  - `FetchCountF` +1 on each edge where IF/ID captures a non-squashed instruction (`StallD` = 0, `PCSrcD` = 0).
  - `StallCountF` +1 on each edge with `StallF` = 1.
- Macro undefined: neither the ports nor the counter logic exist. All other behaviour is identical.

## Test plan
- **Reset and sequential fetch:** load imem[0..3] = 32'h11, 22, 33, 44; deassert `rst_n` -> `InstrD` = 0 for the first cycle, then 11, 22, 33; `PCPlus1D` = 1, 2, 3; `PCF` = 1, 2, 3, 4.
- **Stall:** assert `StallF` = `StallD` = 1 for 2 cycles while `PCF` = 2 -> `PCF` stays 2 and `InstrD` stays 22; on release, `InstrD` = 33 at the next edge.
- **Taken branch:** `PCSrcD` = 1 with `PCBranchD` = 8'hF0 for one cycle -> next cycle `PCF` = F0 and `InstrD` = 0, `PCPlus1D` = 0; following cycle `InstrD` = imem[F0], `PCPlus1D` = F1.
- **Wrap:** branch to FF -> `InstrD` = imem[FF] with `PCPlus1D` = 0, then `InstrD` = imem[0]; `PCSrcD` with stalls asserted -> PC unchanged.
- **Load during fetch:** write 32'hDEAD_BEEF to the current `PCF` -> `InstrD` shows the old word; rewinding fetch to that address shows DEADBEEF.
- **With `FETCH_PERF_CNT_EN`:** 10 plain fetches, 3 stall cycles and 1 branch -> `FetchCountF` = 10, `StallCountF` = 3; async reset mid-run -> both 0 immediately.
